// File: rtl/cv32e40p_pkg.sv
// Package: cv32e40p_pkg
// Shared types and constants for the illegal-instruction event recorder.
//   ILLEGAL_EVT_HART_W : number of hart-ID bits kept per record
//   ILLEGAL_EVT_SEQ_W  : width of the seq field stored in a record
//   illegal_evt_t      : one captured record {pc, hart, seq[, tstamp]}
// Optional feature macro: CV32E40P_EVT_TIMESTAMP_EN adds a 32-bit tstamp field.
package cv32e40p_pkg;

  localparam int ILLEGAL_EVT_HART_W = 4;
  localparam int ILLEGAL_EVT_SEQ_W  = 8;

  typedef struct packed {
    logic [31:0]                   pc;
    logic [ILLEGAL_EVT_HART_W-1:0] hart;
    logic [ILLEGAL_EVT_SEQ_W-1:0]  seq;
`ifdef CV32E40P_EVT_TIMESTAMP_EN
    logic [31:0]                   tstamp;
`endif
  } illegal_evt_t;

endpackage

// File: rtl/cv32e40p_evt_fifo.sv
// Module: cv32e40p_evt_fifo
// Generic synchronous FIFO of illegal_evt_t records. Holds no event logic.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : request to write data_i; accepted when not full, or when
//                  full and a pop happens in the same cycle
//   data_i       : record to write
//   pop_i        : remove the head record (ignored while empty)
//   data_o       : head record, all-zero while empty
//   full_o       : FIFO holds DEPTH records
//   empty_o      : FIFO holds no records
// Handshake: the consumer side is valid = !empty_o, ready = pop_i; a record
// leaves only on a cycle where both are high at the rising edge.
module cv32e40p_evt_fifo
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  illegal_evt_t data_i,
  input  logic         pop_i,
  output illegal_evt_t data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  illegal_evt_t mem_q [DEPTH];

  logic do_pop;
  logic do_push;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/cv32e40p_illegal_insn_recorder.sv
// Module: cv32e40p_illegal_insn_recorder
// Captures illegal-instruction events seen in ID into a small FIFO and
// presents them as records on a valid/ready read port.
// Optional feature macro: CV32E40P_EVT_TIMESTAMP_EN (adds a free-running
// cycle counter stored per record and the evt_tstamp_o port).
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   is_decoding_i       : ID decodes a valid instruction this cycle
//   illegal_insn_dec_i  : decoder flags the ID instruction illegal
//   hart_id_i           : hart ID, bits [3:0] recorded
//   pc_id_i             : PC of the ID instruction
//   clear_i             : clears overflow_o and drop_cnt_o (wins over a drop)
//   evt_valid_o/evt_ready_i : read handshake; a record transfers when both are
//                         high at a rising edge; head data holds while valid & !ready
//   evt_pc_o, evt_hart_o, evt_seq_o [, evt_tstamp_o] : head record fields
//   overflow_o          : sticky, an event was dropped on a full FIFO
//   drop_cnt_o          : saturating count of dropped events
module cv32e40p_illegal_insn_recorder
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int SEQ_W      = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          is_decoding_i,
  input  logic                          illegal_insn_dec_i,
  input  logic [31:0]                   hart_id_i,
  input  logic [31:0]                   pc_id_i,
  input  logic                          clear_i,
  output logic                          evt_valid_o,
  input  logic                          evt_ready_i,
  output logic [31:0]                   evt_pc_o,
  output logic [ILLEGAL_EVT_HART_W-1:0] evt_hart_o,
  output logic [SEQ_W-1:0]              evt_seq_o,
`ifdef CV32E40P_EVT_TIMESTAMP_EN
  output logic [31:0]                   evt_tstamp_o,
`endif
  output logic                          overflow_o,
  output logic [DROP_CNT_W-1:0]         drop_cnt_o
);

  logic                  evt;
  logic                  dup;
  logic                  accept;
  logic                  drop;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  illegal_evt_t          wr_rec;
  illegal_evt_t          head_rec;

  logic                  prev_evt_q;
  logic [31:0]           prev_pc_q;
  logic [SEQ_W-1:0]      seq_q;
  logic                  overflow_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // Upper hart bits are intentionally not recorded.
  logic unused_hart_bits;
  assign unused_hart_bits = ^hart_id_i[31:ILLEGAL_EVT_HART_W];

  assign evt = is_decoding_i & illegal_insn_dec_i;
  // A stalled ID stage re-presents the same PC on back-to-back cycles; only
  // the first cycle counts. Any cycle without an event re-arms capture.
  assign dup    = evt & prev_evt_q & (pc_id_i == prev_pc_q);
  assign accept = evt & ~dup;
  assign pop    = evt_valid_o & evt_ready_i;
  assign drop   = accept & fifo_full & ~pop;

`ifdef CV32E40P_EVT_TIMESTAMP_EN
  logic [31:0] tstamp_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) tstamp_q <= '0;
    else       tstamp_q <= tstamp_q + 32'd1;
  end
`endif

  always_comb begin
    wr_rec      = '0;
    wr_rec.pc   = pc_id_i;
    wr_rec.hart = hart_id_i[ILLEGAL_EVT_HART_W-1:0];
    wr_rec.seq  = ILLEGAL_EVT_SEQ_W'(seq_q);
`ifdef CV32E40P_EVT_TIMESTAMP_EN
    wr_rec.tstamp = tstamp_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_evt_q <= 1'b0;
      prev_pc_q  <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      prev_evt_q <= evt;
      prev_pc_q  <= pc_id_i;
      // Dropped events do not consume a sequence number.
      if (accept && !drop) seq_q <= seq_q + SEQ_W'(1);
      if (clear_i) begin
        overflow_q <= 1'b0;
        drop_cnt_q <= '0;
      end else if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
      end
    end
  end

  cv32e40p_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (wr_rec),
    .pop_i   (pop),
    .data_o  (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt_valid_o = ~fifo_empty;
  assign evt_pc_o    = head_rec.pc;
  assign evt_hart_o  = head_rec.hart;
  assign evt_seq_o   = SEQ_W'(head_rec.seq);
`ifdef CV32E40P_EVT_TIMESTAMP_EN
  assign evt_tstamp_o = head_rec.tstamp;
`endif
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule
